// File: rtl/peg_l2_rs_rmii_rx.sv
// peg_l2_rs_rmii_rx: RMII receive reconciliation sublayer; strips preamble/SFD and
// assembles LSB-first dibits into a byte stream with sop/eop, size and error.
module peg_l2_rs_rmii_rx #(
  parameter int PKT_DATA_W = 8,
  parameter int PKT_SIZE_W = 16
) (
  input  logic                  rmii_ref_clk,
  input  logic                  rst_n,
  input  logic                  config_rs_mii_speed_100_n_10,
  input  logic [1:0]            rmii_rxd,
  input  logic                  rmii_crs_dv,
  input  logic                  rmii_rx_er,
  output logic                  pkt_valid,
  output logic                  pkt_sop,
  output logic                  pkt_eop,
  output logic [PKT_DATA_W-1:0] pkt_data,
  output logic [PKT_SIZE_W-1:0] pkt_size,
  output logic                  pkt_error
);
  typedef enum logic [2:0] {WAIT_S, IDLE_S, PRE_S, DATA_S, DROP_S} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] s_rxd;
  logic s_dv, s_er, s_vld, sp;
  logic seen, seen_n, pend, pend_n, err, err_n, hold_vld, hold_vld_n;
  logic [1:0] idx, idx_n, ei;
  logic [PKT_DATA_W-1:0] sh, sh_n, hold, hold_n, nb;
  logic [PKT_SIZE_W-1:0] scnt, scnt_n, sinc;
  logic emit, eof;
  assign sp = config_rs_mii_speed_100_n_10 | (cnt == 4'd4);
  assign cnt_n = ((state == WAIT_S) || (state == IDLE_S && !rmii_crs_dv)) ? 4'd0 :
                 (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
  assign ei = idx + {1'b0, pend};
  assign sinc = &scnt ? scnt : scnt + 1'b1;
  always_comb begin
    state_n = state;
    seen_n = seen;
    pend_n = pend;
    err_n = err;
    hold_vld_n = hold_vld;
    idx_n = idx;
    sh_n = sh;
    hold_n = hold;
    scnt_n = scnt;
    emit = 1'b0;
    eof = 1'b0;
    nb = sh;
    nb[{ei, 1'b0} +: 2] = s_rxd;
    case (state)
      WAIT_S: if (!rmii_crs_dv) state_n = IDLE_S;
      IDLE_S: if (rmii_crs_dv) begin
        state_n = PRE_S;
        seen_n = 1'b0;
      end
      PRE_S: if (s_vld) begin
        if (!s_dv) state_n = IDLE_S;
        else if (s_rxd == 2'b01) seen_n = 1'b1;
        else if (s_rxd == 2'b11 && seen) begin
          state_n = DATA_S;
          idx_n = '0;
          pend_n = 1'b0;
          err_n = 1'b0;
          hold_vld_n = 1'b0;
          sh_n = '0;
          scnt_n = '0;
        end else if (s_rxd != 2'b00 || seen) state_n = DROP_S;
      end
      DATA_S: if (s_vld) begin
        err_n = err | s_er;
        // a lone low sample is provisional data; a second one ends the frame
        if (!s_dv && pend) begin
          eof = 1'b1;
          emit = hold_vld;
          state_n = IDLE_S;
        end else if (!s_dv) begin
          sh_n[{idx, 1'b0} +: 2] = s_rxd;
          pend_n = 1'b1;
        end else if (pend && idx == 2'd3) begin
          pend_n = 1'b0;
          emit = hold_vld;
          hold_n = sh;
          hold_vld_n = 1'b1;
          sh_n = '0;
          sh_n[1:0] = s_rxd;
          idx_n = 2'd1;
        end else begin
          pend_n = 1'b0;
          sh_n = nb;
          idx_n = ei + 2'd1;
          if (ei == 2'd3) begin
            emit = hold_vld;
            hold_n = nb;
            hold_vld_n = 1'b1;
          end
        end
      end
      DROP_S: if (s_vld && !s_dv) state_n = IDLE_S;
      default: state_n = WAIT_S;
    endcase
    if (emit) scnt_n = sinc;
  end
  always_ff @(posedge rmii_ref_clk or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_S;
      cnt <= '0;
      s_rxd <= '0;
      s_dv <= 1'b0;
      s_er <= 1'b0;
      s_vld <= 1'b0;
      seen <= 1'b0;
      pend <= 1'b0;
      err <= 1'b0;
      hold_vld <= 1'b0;
      idx <= '0;
      sh <= '0;
      hold <= '0;
      scnt <= '0;
      pkt_valid <= 1'b0;
      pkt_sop <= 1'b0;
      pkt_eop <= 1'b0;
      pkt_error <= 1'b0;
      pkt_data <= '0;
      pkt_size <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      s_vld <= sp;
      if (sp) begin
        s_rxd <= rmii_rxd;
        s_dv <= rmii_crs_dv;
        s_er <= rmii_rx_er;
      end
      seen <= seen_n;
      pend <= pend_n;
      err <= err_n;
      hold_vld <= hold_vld_n;
      idx <= idx_n;
      sh <= sh_n;
      hold <= hold_n;
      scnt <= scnt_n;
      pkt_valid <= emit;
      pkt_sop <= emit & ~|scnt;
      pkt_eop <= emit & eof;
      pkt_error <= emit & eof & (err_n | (|idx));
      if (emit) begin
        pkt_data <= hold;
        pkt_size <= sinc;
      end
    end
endmodule
